mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_watchdog.sv | 28 ++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

  localparam int WD_W = 16;

endpackage

// File: rtl/mem_watchdog.sv
// Cycle counter that flags when a transaction has waited limit cycles for its ack.
module mem_watchdog
  import mem_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  input  logic [WD_W-1:0] limit,
  output logic            expired
);

  logic [WD_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WD_W'(1);
    end
  end

  // A zero limit disables expiry entirely.
  assign expired = enable && (limit != '0) && (count == limit - WD_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the io_ctrl memory port between two requesters,
// one transaction in flight, with a watchdog abort for missing acks.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_ack,
  output logic              r0_err,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_ack,
  output logic              r1_err,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              owner,
  output logic              busy
);

  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  arb_state_e        state, state_next;
  op_e               op, grant_op;
  logic              last_served;
  logic              req0, req1;
  logic              grant, grant_port, finish;
  logic              wd_enable, expired;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_wdata;

  assign req0      = r0_read | r0_write;
  assign req1      = r1_read | r1_write;
  assign wd_enable = (state == BUSY);

  mem_watchdog u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (grant),
    .enable  (wd_enable),
    .limit   (WD_LIMIT),
    .expired (expired)
  );

  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    grant_port  = last_served;
    finish      = 1'b0;
    grant_op    = OP_READ;
    grant_addr  = r0_addr;
    grant_wdata = r0_wdata;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant      = 1'b1;
          grant_port = (req0 && req1) ? ~last_served : req1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // m_ack takes priority over a simultaneous watchdog expiry.
        if (m_ack || expired) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (grant_port) begin
      grant_op    = r1_write ? OP_WRITE : OP_READ;
      grant_addr  = r1_addr;
      grant_wdata = r1_wdata;
    end else begin
      grant_op    = r0_write ? OP_WRITE : OP_READ;
      grant_addr  = r0_addr;
      grant_wdata = r0_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op          <= OP_READ;
      last_served <= 1'b1;
      owner       <= 1'b0;
      busy        <= 1'b0;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      r0_ack      <= 1'b0;
      r0_err      <= 1'b0;
      r0_rdata    <= '0;
      r1_ack      <= 1'b0;
      r1_err      <= 1'b0;
      r1_rdata    <= '0;
    end else begin
      state  <= state_next;
      busy   <= (state_next != IDLE);
      r0_ack <= 1'b0;
      r0_err <= 1'b0;
      r1_ack <= 1'b0;
      r1_err <= 1'b0;
      if (grant) begin
        owner   <= grant_port;
        op      <= grant_op;
        m_addr  <= grant_addr;
        m_wdata <= grant_wdata;
        m_read  <= (grant_op == OP_READ);
        m_write <= (grant_op == OP_WRITE);
      end
      if (finish) begin
        m_read      <= 1'b0;
        m_write     <= 1'b0;
        last_served <= owner;
        if (owner) begin
          r1_ack <= 1'b1;
          r1_err <= ~m_ack;
          if (m_ack && op == OP_READ) r1_rdata <= m_rdata;
        end else begin
          r0_ack <= 1'b1;
          r0_err <= ~m_ack;
          if (m_ack && op == OP_READ) r0_rdata <= m_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r0_read = 1'b0, r0_write = 1'b0;
  logic [AW-1:0] r0_addr = '0;
  logic [DW-1:0] r0_wdata = '0;
  logic [DW-1:0] r0_rdata;
  logic          r0_ack, r0_err;
  logic          r1_read = 1'b0, r1_write = 1'b0;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_wdata = '0;
  logic [DW-1:0] r1_rdata;
  logic          r1_ack, r1_err;
  logic          m_read, m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ack = 1'b0;
  logic          owner, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_read(r0_read), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_rdata(r0_rdata), .r0_ack(r0_ack), .r0_err(r0_err),
    .r1_read(r1_read), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_rdata(r1_rdata), .r1_ack(r1_ack), .r1_err(r1_err),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .owner(owner), .busy(busy)
  );

  int            tests = 0;
  int            fails = 0;
  int            last_m = 1;
  logic [DW-1:0] rexp [2] = '{'0, '0};
  int            grants [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic req_of(input int p);
    return p != 0 ? (r1_read | r1_write) : (r0_read | r0_write);
  endfunction
  function automatic logic wr_of(input int p);
    return p != 0 ? r1_write : r0_write;
  endfunction
  function automatic logic [AW-1:0] addr_of(input int p);
    return p != 0 ? r1_addr : r0_addr;
  endfunction
  function automatic logic [DW-1:0] wdata_of(input int p);
    return p != 0 ? r1_wdata : r0_wdata;
  endfunction
  function automatic logic ack_of(input int p);
    return p != 0 ? r1_ack : r0_ack;
  endfunction
  function automatic logic err_of(input int p);
    return p != 0 ? r1_err : r0_err;
  endfunction
  function automatic logic [DW-1:0] rdata_of(input int p);
    return p != 0 ? r1_rdata : r0_rdata;
  endfunction

  task automatic set_req(input int p, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p != 0) begin
      r1_read = rd; r1_write = wr; r1_addr = a; r1_wdata = d;
    end else begin
      r0_read = rd; r0_write = wr; r0_addr = a; r0_wdata = d;
    end
  endtask

  task automatic rand_req(input int p);
    int kind;
    kind = $urandom_range(0, 2);
    set_req(p, kind != 1, kind != 0, $urandom, $urandom);
  endtask

  // Called at a negedge with the arbiter idle and requests already applied.
  // lat: BUSY cycle (1-based) in which io_ctrl acks; 0 or > TO means never.
  task automatic do_txn(input int lat, input bit stray, input logic [DW-1:0] data);
    int            p, k;
    bit            exp_err, exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    if (req_of(0) && req_of(1)) p = 1 - last_m;
    else p = req_of(1) ? 1 : 0;
    exp_wr    = wr_of(p);
    exp_addr  = addr_of(p);
    exp_wdata = wdata_of(p);
    exp_err   = !(lat >= 1 && lat <= TO);

    @(negedge clk);
    check("grant_owner", owner, p);
    check("grant_m_write", m_write, exp_wr);
    check("grant_m_read", m_read, !exp_wr);
    check("grant_m_addr", m_addr, exp_addr);
    check("grant_m_wdata", m_wdata, exp_wdata);
    check("grant_busy", busy, 1);

    k = 1;
    forever begin
      if (k == lat) begin
        m_ack = 1'b1;
        m_rdata = data;
      end
      @(negedge clk);
      m_ack = 1'b0;
      m_rdata = $urandom;
      if (!(m_read || m_write)) break;
      check("busy_no_ack", {r0_ack, r1_ack}, 0);
      k++;
      if (k > TO + 1) begin
        check("busy_bound", k, TO);
        break;
      end
    end

    check("busy_cycles", k, exp_err ? TO : lat);
    if (!exp_err && !exp_wr) rexp[p] = data;
    check("done_ack", ack_of(p), 1);
    check("done_err", err_of(p), exp_err);
    check("done_rdata", rdata_of(p), rexp[p]);
    check("other_ack", {ack_of(1 - p), err_of(1 - p)}, 0);
    check("other_rdata", rdata_of(1 - p), rexp[1 - p]);
    check("done_busy", busy, 1);
    last_m = p;
    grants.push_back(p);

    set_req(p, 1'b0, 1'b0, addr_of(p), wdata_of(p));
    if (stray) begin
      m_ack = 1'b1;
      m_rdata = $urandom;
    end
    @(negedge clk);
    m_ack = 1'b0;
    check("idle_acks", {r0_ack, r1_ack, r0_err, r1_err}, 0);
    check("idle_busy_m", {busy, m_read, m_write}, 0);
    check("idle_rdata", rdata_of(p), rexp[p]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int base;

    repeat (2) @(negedge clk);
    check("rst_ctrl", {m_read, m_write, owner, busy, r0_ack, r0_err, r1_ack, r1_err}, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_rdata", {r0_rdata, r1_rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention straight after reset: port 0 first, then port 1's write.
    set_req(0, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
    set_req(1, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_005A);
    do_txn(2, 1'b0, 32'h1234_5678);
    do_txn(1, 1'b0, 32'hFFFF_FFFF);
    check("contention_order", {grants[0][0], grants[1][0]}, 2'b01);

    // Single read with a slow ack.
    set_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    do_txn(3, 1'b0, 32'hDEAD_BEEF);
    check("single_rdata", r0_rdata, 32'hDEAD_BEEF);

    // Fairness: both ports keep requesting.
    base = grants.size();
    rand_req(0);
    rand_req(1);
    for (int i = 0; i < 4; i++) begin
      do_txn($urandom_range(1, 4), 1'b0, $urandom);
      rand_req(grants[grants.size() - 1]);
    end
    for (int i = 1; i < 4; i++)
      check("fair_alternate", grants[base + i] ^ grants[base + i - 1], 1);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);

    // Watchdog abort on port 1 with a stray late ack in DONE.
    set_req(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    do_txn(0, 1'b1, 32'hBAD0_BAD0);

    // Ack in the very cycle the watchdog would expire.
    set_req(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
    do_txn(TO, 1'b0, 32'hC0FF_EE00);

    // Asynchronous reset in the middle of a port 0 write.
    set_req(0, 1'b0, 1'b1, 32'h0000_0500, 32'hA5A5_A5A5);
    @(negedge clk);
    check("pre_rst_m_write", m_write, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_m_write", m_write, 0);
    check("rst_mid_busy_ack", {busy, r0_ack, r0_err}, 0);
    check("rst_mid_rdata", {r0_rdata, r1_rdata}, 0);
    set_req(1, 1'b1, 1'b0, 32'h0000_0600, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_m = 1;
    rexp[0] = '0;
    rexp[1] = '0;
    do_txn(2, 1'b0, 32'h0BAD_F00D);
    check("rst_first_grant", grants[grants.size() - 1], 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      if (!req_of(0) && $urandom_range(0, 1) == 1) rand_req(0);
      if (!req_of(1) && $urandom_range(0, 1) == 1) rand_req(1);
      if (!req_of(0) && !req_of(1)) rand_req($urandom_range(0, 1));
      do_txn($urandom_range(0, TO + 2), bit'($urandom_range(0, 1)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
